sseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It sits directly upstream of SSEG_Decoder. Each slot it selects one digit's 4-bit nibble and drives it onto Num, which feeds the decoder. In the same slot it drives the matching active-low anode. Captures new display values atomically at frame boundaries so digits never tear mid-frame.

---
 rtl/sseg_pkg.sv | 21 ++
 rtl/sseg_tick_gen.sv | 28 ++
 rtl/sseg_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan controller
// and its SSEG_Decoder integration benches.
package sseg_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int SSEG_NUM_DIGITS = 4;
  localparam int SSEG_PRESCALE   = 50000;

  typedef enum logic {
    PEND_IDLE,
    PEND_FULL
  } pend_e;

  // all-ones anode pattern for n digits (n <= 8), low bits used
  function automatic logic [7:0] ANODE_OFF(input int n);
    ANODE_OFF = '0;
    for (int i = 0; i < 8; i++)
      if (i < n) ANODE_OFF[i] = 1'b1;
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last count.
// tick is high for the whole final cycle of each slot.
module sseg_tick_gen #(
  parameter int PRESCALE = 4,
  localparam int CNT_W = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode scan controller feeding SSEG_Decoder.
// Define SSEG_LZB_EN to enable leading-zero blanking.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = SSEG_NUM_DIGITS,
  parameter int PRESCALE   = SSEG_PRESCALE,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int DW    = NIBBLE_W * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Load,
  input  logic [DW-1:0]         Value,
  input  logic [NUM_DIGITS-1:0] BlankMask,
  output logic [NIBBLE_W-1:0]   Num,
  output logic [NUM_DIGITS-1:0] Anode,
  output logic [IDX_W-1:0]      DigitIdx,
  output logic                  LoadAck
);

  localparam logic [7:0] OFF8 = ANODE_OFF(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] OFF = OFF8[NUM_DIGITS-1:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic                  tick;
  logic                  frame_end;
  logic                  apply;
  logic                  dark;
  pend_e                 pst;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_n;
  logic [DW-1:0]         disp_val;
  logic [DW-1:0]         disp_val_n;
  logic [DW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] disp_blank;
  logic [NUM_DIGITS-1:0] disp_blank_n;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic [NUM_DIGITS-1:0] anode_n;
  logic [NIBBLE_W-1:0]   num_n;

  sseg_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign frame_end = tick && (idx == LAST_IDX);
  assign DigitIdx  = idx;

`ifdef SSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_above;

  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above &&
        (disp_val_n[NIBBLE_W*k +: NIBBLE_W] == '0);
      lz[k] = zero_above;
    end
  end
`endif

  // outputs are built from next-state so idx, data and anode move together
  always_comb begin
    idx_n        = idx;
    disp_val_n   = disp_val;
    disp_blank_n = disp_blank;
    apply        = 1'b0;
    if (tick) begin
      idx_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
    if (frame_end) begin
      if (Load) begin
        disp_val_n   = Value;
        disp_blank_n = BlankMask;
        apply        = 1'b1;
      end else if (pst == PEND_FULL) begin
        disp_val_n   = pend_val;
        disp_blank_n = pend_blank;
        apply        = 1'b1;
      end
    end
    num_n = disp_val_n[NIBBLE_W*idx_n +: NIBBLE_W];
    dark  = disp_blank_n[idx_n];
`ifdef SSEG_LZB_EN
    dark  = dark || lz[idx_n];
`endif
    anode_n = dark ? OFF : ~(ONE << idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      pst        <= PEND_IDLE;
      disp_val   <= '0;
      disp_blank <= '0;
      pend_val   <= '0;
      pend_blank <= '0;
      Num        <= '0;
      Anode      <= OFF;
      LoadAck    <= 1'b0;
    end else begin
      idx        <= idx_n;
      disp_val   <= disp_val_n;
      disp_blank <= disp_blank_n;
      Num        <= num_n;
      Anode      <= anode_n;
      LoadAck    <= apply;
      if (frame_end) begin
        pst <= PEND_IDLE;
      end else if (Load) begin
        pend_val   <= Value;
        pend_blank <= BlankMask;
        pst        <= PEND_FULL;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (4 digits, PRESCALE=4).
// Follows the SSEG_LZB_EN define of the build for expected anodes.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  BlankMask = '0;
  logic [3:0]  Num;
  logic [3:0]  Anode;
  logic [1:0]  DigitIdx;
  logic        LoadAck;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .NUM_DIGITS(4),
    .PRESCALE  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Load     (Load),
    .Value    (Value),
    .BlankMask(BlankMask),
    .Num      (Num),
    .Anode    (Anode),
    .DigitIdx (DigitIdx),
    .LoadAck  (LoadAck)
  );

  // an/nm hold per-slot expectations, slot 0 in bits [3:0]
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [15:0] an;
    logic [15:0] nm;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nm;
    logic       ack;
    logic [1:0] idx;
  } exp_t;

`ifdef SSEG_LZB_EN
  localparam logic [15:0] AN_0070 = 16'hFFDE;
  localparam logic [15:0] AN_0007 = 16'hFFFE;
  localparam logic [15:0] AN_ZERO = 16'hFFFE;
`else
  localparam logic [15:0] AN_0070 = 16'h7BDE;
  localparam logic [15:0] AN_0007 = 16'h7BDE;
  localparam logic [15:0] AN_ZERO = 16'h7BDE;
`endif

  localparam int NV = 7;

  vec_t vecs [NV];
  vec_t vzero, vabcd, v2222, v5555;
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] b);
    Value     = v;
    BlankMask = b;
    Load      = 1'b1;
    step();
    Load      = 1'b0;
  endtask

  task automatic wait_ack(input int lim);
    int i = 0;
    while (LoadAck !== 1'b1 && i < lim) begin
      step();
      i++;
    end
    check("ack_seen", {31'd0, LoadAck}, 32'd1);
  endtask

  // frame samples j..15; each slot is 4 samples long
  task automatic push_range(input vec_t v, input int from,
                            input logic first_ack);
    exp_t e;
    for (int j = from; j < 16; j++) begin
      e.an  = v.an[4*(j/4) +: 4];
      e.nm  = v.nm[4*(j/4) +: 4];
      e.ack = first_ack && (j == from);
      e.idx = 2'(j / 4);
      sb.push_back(e);
    end
  endtask

  // compares the current sample, then steps for each further entry
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("anode", {28'd0, Anode}, {28'd0, e.an});
      check("num", {28'd0, Num}, {28'd0, e.nm});
      check("ack", {31'd0, LoadAck}, {31'd0, e.ack});
      check("idx", {30'd0, DigitIdx}, {30'd0, e.idx});
      if (sb.size() > 0) step();
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'h0, 16'h7BDE, 16'h1234};
    vecs[1] = '{16'hABCD, 4'h0, 16'h7BDE, 16'hABCD};
    vecs[2] = '{16'h1234, 4'h4, 16'h7FDE, 16'h1234};
    vecs[3] = '{16'h0070, 4'h0, AN_0070,  16'h0070};
    vecs[4] = '{16'h0007, 4'h0, AN_0007,  16'h0007};
    vecs[5] = '{16'hFFFF, 4'hF, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{16'h8001, 4'h0, 16'h7BDE, 16'h8001};
    vzero   = '{16'h0000, 4'h0, AN_ZERO,  16'h0000};
    vabcd   = '{16'hABCD, 4'h0, 16'h7BDE, 16'hABCD};
    v2222   = '{16'h2222, 4'h0, 16'h7BDE, 16'h2222};
    v5555   = '{16'h5555, 4'h0, 16'h7BDE, 16'h5555};

    // reset values while clock runs
    repeat (3) step();
    check("rst_anode", {28'd0, Anode}, 32'hF);
    check("rst_num", {28'd0, Num}, 32'h0);
    check("rst_ack", {31'd0, LoadAck}, 32'h0);
    check("rst_idx", {30'd0, DigitIdx}, 32'h0);

    // release: digit 0 after one edge, shortened first slot, no load
    rst_n = 1'b1;
    step();
    push_range(vzero, 1, 1'b0);
    drain();

    // table: odd entries load mid-frame, even ones on the boundary
    for (int i = 0; i < NV; i++) begin
      if (i % 2 == 1) repeat (6) step();
      push_range(vecs[i], 0, 1'b1);
      load(vecs[i].value, vecs[i].blank);
      wait_ack(40);
      drain();
    end

    // atomic update: mid-frame load held until the boundary
    repeat (5) step();
    load(16'hABCD, 4'h0);
    push_range(vecs[NV-1], 5, 1'b0);
    push_range(vabcd, 0, 1'b1);
    drain();

    // latest wins: two loads in one frame, one ack
    repeat (5) step();
    load(16'h1111, 4'h0);
    repeat (4) step();
    load(16'h2222, 4'h0);
    push_range(vabcd, 10, 1'b0);
    push_range(v2222, 0, 1'b1);
    drain();
    step();
    push_range(v2222, 0, 1'b0);
    drain();

    // load on the boundary cycle applies that edge, nothing left pending
    load(16'h5555, 4'h0);
    push_range(v5555, 0, 1'b1);
    drain();
    step();
    push_range(v5555, 0, 1'b0);
    drain();

    // reset mid-frame discards pending data
    repeat (5) step();
    load(16'h9999, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_anode", {28'd0, Anode}, 32'hF);
    check("mid_rst_num", {28'd0, Num}, 32'h0);
    check("mid_rst_ack", {31'd0, LoadAck}, 32'h0);
    check("mid_rst_idx", {30'd0, DigitIdx}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    push_range(vzero, 1, 1'b0);
    drain();
    step();
    push_range(vzero, 0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
